// File: rtl/tron_pkg.sv
// Shared constants and FSM encoding for the light-cycle collision arbiter.
package tron_pkg;
    localparam int TRON_X_W   = 8;
    localparam int TRON_Y_W   = 7;
    localparam int TRON_X_MAX = 159;
    localparam int TRON_Y_MAX = 119;
    localparam int PID_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RESOLVE = 2'd3
    } state_t;
endpackage

// File: rtl/tron_rd_tag_pipe.sv
// Delay line of {valid, player index} matching the trail BRAM read latency,
// so each returned bit can be credited to the player that requested it.
module tron_rd_tag_pipe #(
    parameter int RD_LAT = 1,
    parameter int PID_W  = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PID_W-1:0] in_idx,
    output logic             out_valid,
    output logic [PID_W-1:0] out_idx
);
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic             v_reg;
            logic [PID_W-1:0] idx_reg;
            logic             v_in;
            logic [PID_W-1:0] idx_in;
            if (gi == 0) begin : g_head
                assign v_in   = in_valid;
                assign idx_in = in_idx;
            end else begin : g_tail
                assign v_in   = g_stage[gi-1].v_reg;
                assign idx_in = g_stage[gi-1].idx_reg;
            end
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    v_reg   <= 1'b0;
                    idx_reg <= '0;
                end else begin
                    v_reg   <= v_in & ~flush;
                    idx_reg <= idx_in;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[RD_LAT-1].v_reg;
    assign out_idx   = g_stage[RD_LAT-1].idx_reg;
endmodule

// File: rtl/tron_collision_arbiter.sv
// Per-step loss detection for N players: trail hits via the shared BRAM,
// out-of-bounds moves and head-on collisions, followed by winner/draw resolution.
module tron_collision_arbiter
    import tron_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int X_W       = TRON_X_W,
    parameter int Y_W       = TRON_Y_W,
    parameter int X_MAX     = TRON_X_MAX,
    parameter int Y_MAX     = TRON_Y_MAX,
    parameter int RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     step,
    input  logic [N_PLAYERS*X_W-1:0] px,
    input  logic [N_PLAYERS*Y_W-1:0] py,
    input  logic                     round_clear,
    output logic                     mem_rd_en,
    output logic [X_W-1:0]           mem_rd_x,
    output logic [Y_W-1:0]           mem_rd_y,
    input  logic                     mem_rd_data,
    output logic [N_PLAYERS-1:0]     lost,
    output logic                     busy,
    output logic                     eval_done,
    output logic                     game_over,
    output logic [2:0]               winner_id,
    output logic                     draw,
    output logic                     step_overrun
);
    localparam int DR_W = $clog2(RD_LAT + 2);
    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    state_t                   state_reg, state_next;
    logic [N_PLAYERS*X_W-1:0] snap_x_reg;
    logic [N_PLAYERS*Y_W-1:0] snap_y_reg;
    logic [PID_W-1:0]         idx_reg;
    logic [DR_W-1:0]          drain_cnt_reg;
    logic [N_PLAYERS-1:0]     hit_reg, lost_reg;
    logic                     game_over_reg, draw_reg, overrun_reg, eval_done_reg;
    logic [PID_W-1:0]         winner_reg;
    logic                     rd_valid_q, rd_data_q;
    logic [PID_W-1:0]         rd_idx_q;
    logic                     tag_valid;
    logic [PID_W-1:0]         tag_idx;
    logic [N_PLAYERS-1:0]     oob, headon, lost_upd;
    logic [3:0]               alive_cnt;
    logic [PID_W-1:0]         survivor;

    assign busy      = (state_reg != ST_IDLE);
    assign mem_rd_en = (state_reg == ST_ISSUE);
    assign mem_rd_x  = mem_rd_en ? snap_x_reg[idx_reg*X_W +: X_W] : '0;
    assign mem_rd_y  = mem_rd_en ? snap_y_reg[idx_reg*Y_W +: Y_W] : '0;

    tron_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .PID_W  (PID_W)
    ) u_tag_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (round_clear),
        .in_valid  (mem_rd_en),
        .in_idx    (idx_reg),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Drain runs one cycle past RD_LAT because returned data is registered before use.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (step && !game_over_reg) state_next = ST_ISSUE;
            ST_ISSUE:   if (idx_reg == PID_W'(N_PLAYERS - 1)) state_next = ST_DRAIN;
            ST_DRAIN:   if (drain_cnt_reg == DR_W'(RD_LAT)) state_next = ST_RESOLVE;
            ST_RESOLVE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (round_clear) state_next = ST_IDLE;
    end

    always_comb begin
        oob       = '0;
        headon    = '0;
        alive_cnt = '0;
        survivor  = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            oob[i] = (snap_x_reg[i*X_W +: X_W] > X_LIM) || (snap_y_reg[i*Y_W +: Y_W] > Y_LIM);
            for (int j = 0; j < N_PLAYERS; j++) begin
                if (j != i && !lost_reg[j] &&
                    snap_x_reg[i*X_W +: X_W] == snap_x_reg[j*X_W +: X_W] &&
                    snap_y_reg[i*Y_W +: Y_W] == snap_y_reg[j*Y_W +: Y_W])
                    headon[i] = 1'b1;
            end
        end
        lost_upd = lost_reg | hit_reg | oob | headon;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (!lost_upd[i]) begin
                alive_cnt = alive_cnt + 4'd1;
                survivor  = PID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_x_reg    <= '0;
            snap_y_reg    <= '0;
            idx_reg       <= '0;
            drain_cnt_reg <= '0;
            hit_reg       <= '0;
            lost_reg      <= '0;
            game_over_reg <= 1'b0;
            draw_reg      <= 1'b0;
            winner_reg    <= '0;
            overrun_reg   <= 1'b0;
            eval_done_reg <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= 1'b0;
            rd_idx_q      <= '0;
        end else begin
            eval_done_reg <= 1'b0;
            rd_valid_q    <= tag_valid & ~round_clear;
            rd_data_q     <= mem_rd_data;
            rd_idx_q      <= tag_idx;
            if (state_reg == ST_ISSUE) begin
                idx_reg       <= idx_reg + PID_W'(1);
                drain_cnt_reg <= '0;
            end
            if (state_reg == ST_DRAIN) drain_cnt_reg <= drain_cnt_reg + DR_W'(1);
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (rd_valid_q && rd_data_q && rd_idx_q == PID_W'(i)) hit_reg[i] <= 1'b1;
            end
            if (state_reg == ST_IDLE && state_next == ST_ISSUE) begin
                snap_x_reg <= px;
                snap_y_reg <= py;
                idx_reg    <= '0;
                hit_reg    <= '0;
            end
            if (round_clear) begin
                lost_reg      <= '0;
                game_over_reg <= 1'b0;
                draw_reg      <= 1'b0;
                winner_reg    <= '0;
                overrun_reg   <= 1'b0;
            end else begin
                if (step && busy) overrun_reg <= 1'b1;
                if (state_reg == ST_RESOLVE) begin
                    lost_reg      <= lost_upd;
                    game_over_reg <= (alive_cnt <= 4'd1);
                    draw_reg      <= (alive_cnt == 4'd0);
                    winner_reg    <= (alive_cnt == 4'd1) ? survivor : '0;
                    eval_done_reg <= 1'b1;
                end
            end
        end
    end

    assign lost         = lost_reg;
    assign game_over    = game_over_reg;
    assign draw         = draw_reg;
    assign winner_id    = winner_reg;
    assign step_overrun = overrun_reg;
    assign eval_done    = eval_done_reg;
endmodule
